// File: rtl/gshare_predictor_if.sv
// Request/prediction/resolve bundle for gshare_predictor.
//   master : fetch/execute side; drives req_valid, req_pc, res_valid, res_taken.
//   slave  : predictor side; drives req_ready, pred_valid, pred_taken, mispredict,
//            orphan, pending, ghr.
// DEPTH and HIST_W must match the predictor instance so that the pending and ghr
// widths agree.
interface gshare_predictor_if #(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned HIST_W = 0
);
  localparam int unsigned PendW = $clog2(DEPTH + 1);
  localparam int unsigned GhrW  = (HIST_W > 0) ? HIST_W : 1;

  logic             req_valid;
  logic [PC_W-1:0]  req_pc;
  logic             req_ready;
  logic             pred_valid;
  logic             pred_taken;
  logic             res_valid;
  logic             res_taken;
  logic             mispredict;
  logic             orphan;
  logic [PendW-1:0] pending;
  logic [GhrW-1:0]  ghr;

  modport master (
    output req_valid, req_pc, res_valid, res_taken,
    input  req_ready, pred_valid, pred_taken, mispredict, orphan, pending, ghr
  );

  modport slave (
    input  req_valid, req_pc, res_valid, res_taken,
    output req_ready, pred_valid, pred_taken, mispredict, orphan, pending, ghr
  );
endinterface

// File: rtl/gshare_predictor.sv
// gshare branch direction predictor.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : gshare_predictor_if.slave
//     req_valid/req_pc/req_ready : prediction request, accepted on valid && ready
//     pred_valid/pred_taken      : one-cycle prediction pulse, one cycle after accept
//     res_valid/res_taken        : outcome of the oldest unresolved prediction
//     mispredict                 : pulse when the resolved prediction was wrong
//     orphan                     : pulse when an outcome arrives with nothing pending
//     pending                    : number of unresolved predictions
//     ghr                        : committed global history (0 when HIST_W = 0)
// A table of saturating counters is indexed by pc ^ ghr. Every accepted prediction
// remembers its index and predicted direction in an in-order FIFO so the resolve
// can train the same counter and flag mispredictions.
module gshare_predictor #(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned INIT   = (1 << CNT_W) - 1,
  parameter int unsigned HIST_W = 0,
  parameter int unsigned DEPTH  = 4
) (
  input logic               clk,
  input logic               rst_n,
  gshare_predictor_if.slave bus
);

  localparam int unsigned Entries = 1 << IDX_W;
  localparam int unsigned CntMax  = (1 << CNT_W) - 1;
  localparam int unsigned PendW   = $clog2(DEPTH + 1);
  localparam int unsigned PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned GhrW    = (HIST_W > 0) ? HIST_W : 1;

  // Counter table
  logic [CNT_W-1:0] cnt_q [Entries];
  logic [CNT_W-1:0] cnt_d [Entries];

  // In-flight FIFO
  logic [IDX_W-1:0] fifo_idx_q  [DEPTH];
  logic             fifo_pred_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PendW-1:0] count_q, count_d;

  // Global history and registered outputs
  logic [GhrW-1:0]  ghr_q, ghr_d;
  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic             mispredict_q, mispredict_d;
  logic             orphan_q, orphan_d;

  // Request-side datapath
  logic [IDX_W-1:0] hist_idx;
  logic [IDX_W-1:0] idx;
  logic             pred_bit;
  logic             req_ready;
  logic             accept;

  // Resolve-side datapath
  logic             have_head;
  logic             resolve;
  logic [IDX_W-1:0] head_idx;
  logic             head_pred;
  logic [CNT_W-1:0] head_cnt;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Only the low IDX_W pc bits take part in indexing.
  if (PC_W > IDX_W) begin : g_pc_unused
    logic unused_pc_hi;
    assign unused_pc_hi = ^bus.req_pc[PC_W-1:IDX_W];
  end

  // History is zero-extended into the index; bimodal mode ignores it entirely.
  assign hist_idx = (HIST_W == 0) ? '0 : IDX_W'(ghr_q);
  assign idx      = bus.req_pc[IDX_W-1:0] ^ hist_idx;
  assign pred_bit = cnt_q[idx][CNT_W-1];

  // Ready looks only at the registered count; a same-cycle resolve does not free a slot.
  assign req_ready = (count_q != PendW'(DEPTH));
  assign accept    = bus.req_valid & req_ready;

  assign have_head = (count_q != '0);
  assign resolve   = bus.res_valid & have_head;
  assign head_idx  = fifo_idx_q[rd_ptr_q];
  assign head_pred = fifo_pred_q[rd_ptr_q];
  assign head_cnt  = cnt_q[head_idx];

  // Counter training: saturate at both ends. The prediction above reads cnt_q, so a
  // same-cycle request on the trained index sees the pre-update value.
  always_comb begin
    cnt_d = cnt_q;
    if (resolve) begin
      if (bus.res_taken) begin
        if (head_cnt != CNT_W'(CntMax)) begin
          cnt_d[head_idx] = head_cnt + 1'b1;
        end
      end else if (head_cnt != '0) begin
        cnt_d[head_idx] = head_cnt - 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (accept) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (resolve) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({accept, resolve})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Non-speculative history: shifts only on a real resolve, newest outcome in the LSB.
  always_comb begin
    ghr_d = ghr_q;
    if (HIST_W == 0) begin
      ghr_d = '0;
    end else if (resolve) begin
      ghr_d = GhrW'({ghr_q, bus.res_taken});
    end
  end

  always_comb begin
    pred_valid_d = accept;
    pred_taken_d = accept & pred_bit;
    mispredict_d = resolve & (head_pred ^ bus.res_taken);
    orphan_d     = bus.res_valid & ~have_head;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < Entries; i++) begin
        cnt_q[i] <= CNT_W'(INIT);
      end
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      mispredict_q <= 1'b0;
      orphan_q     <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      ghr_q        <= ghr_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      mispredict_q <= mispredict_d;
      orphan_q     <= orphan_d;
    end
  end

  // FIFO payload needs no reset: entries are only read while counted as pending.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      fifo_idx_q[wr_ptr_q]  <= idx;
      fifo_pred_q[wr_ptr_q] <= pred_bit;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.pred_valid = pred_valid_q;
  assign bus.pred_taken = pred_taken_q;
  assign bus.mispredict = mispredict_q;
  assign bus.orphan     = orphan_q;
  assign bus.pending    = count_q;
  assign bus.ghr        = ghr_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: a bimodal instance (HIST_W=0) and a gshare instance
// (HIST_W=4) receive identical stimulus. A reference model per instance pushes
// expected predictions into a queue; a negedge monitor pops and compares them and
// checks the per-cycle status outputs against the model.
module tb_gshare_predictor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req_valid;
  logic [7:0] req_pc;
  logic       res_valid;
  logic       res_taken;

  gshare_predictor_if #(.PC_W(8), .DEPTH(4), .HIST_W(0)) if0 ();
  gshare_predictor_if #(.PC_W(8), .DEPTH(4), .HIST_W(4)) if1 ();

  assign if0.req_valid = req_valid;
  assign if0.req_pc    = req_pc;
  assign if0.res_valid = res_valid;
  assign if0.res_taken = res_taken;
  assign if1.req_valid = req_valid;
  assign if1.req_pc    = req_pc;
  assign if1.res_valid = res_valid;
  assign if1.res_taken = res_taken;

  gshare_predictor #(
    .PC_W(8), .IDX_W(4), .CNT_W(2), .INIT(3), .HIST_W(0), .DEPTH(4)
  ) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if0)
  );

  gshare_predictor #(
    .PC_W(8), .IDX_W(4), .CNT_W(2), .INIT(3), .HIST_W(4), .DEPTH(4)
  ) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if1)
  );

  // Output views indexed by instance
  logic       pv_w [2];
  logic       pt_w [2];
  logic       mis_w [2];
  logic       orph_w [2];
  logic       rdy_w [2];
  logic [2:0] pend_w [2];
  logic [3:0] ghr_w [2];

  assign pv_w[0]   = if0.pred_valid;
  assign pv_w[1]   = if1.pred_valid;
  assign pt_w[0]   = if0.pred_taken;
  assign pt_w[1]   = if1.pred_taken;
  assign mis_w[0]  = if0.mispredict;
  assign mis_w[1]  = if1.mispredict;
  assign orph_w[0] = if0.orphan;
  assign orph_w[1] = if1.orphan;
  assign rdy_w[0]  = if0.req_ready;
  assign rdy_w[1]  = if1.req_ready;
  assign pend_w[0] = if0.pending;
  assign pend_w[1] = if1.pending;
  assign ghr_w[0]  = {3'b000, if0.ghr};
  assign ghr_w[1]  = if1.ghr;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: counters as plain ints, history as an int, in-flight list as a queue.
  typedef struct {
    int idx;
    bit pred;
  } ent_t;

  ent_t fq [2][$];
  bit   pq [2][$];
  int   cnt [2][16];
  int   hist [2];
  bit   exp_pv [2];
  bit   exp_mis [2];
  bit   exp_orph [2];
  int   exp_pend [2];
  int   exp_ghr [2];
  bit   started = 1'b0;

  always @(posedge clk) begin
    int   hl;
    bit   can_acc;
    bit   have;
    bit   p;
    int   idx;
    ent_t e;
    for (int m = 0; m < 2; m++) begin
      exp_pv[m]   = 1'b0;
      exp_mis[m]  = 1'b0;
      exp_orph[m] = 1'b0;
      if (!rst_n) begin
        for (int i = 0; i < 16; i++) cnt[m][i] = 3;
        hist[m] = 0;
        fq[m].delete();
        started = 1'b1;
      end else begin
        hl      = (m == 1) ? 4 : 0;
        can_acc = fq[m].size() < 4;
        have    = fq[m].size() > 0;
        idx     = 0;
        p       = 1'b0;
        if (req_valid && can_acc) begin
          idx = (int'(req_pc) % 16) ^ hist[m];
          p   = cnt[m][idx] >= 2;
        end
        if (res_valid) begin
          if (have) begin
            e = fq[m].pop_front();
            if (res_taken) begin
              if (cnt[m][e.idx] < 3) cnt[m][e.idx] = cnt[m][e.idx] + 1;
            end else begin
              if (cnt[m][e.idx] > 0) cnt[m][e.idx] = cnt[m][e.idx] - 1;
            end
            if (hl > 0) hist[m] = (hist[m] * 2 + int'(res_taken)) % (1 << hl);
            exp_mis[m] = (e.pred != res_taken);
          end else begin
            exp_orph[m] = 1'b1;
          end
        end
        if (req_valid && can_acc) begin
          e.idx  = idx;
          e.pred = p;
          fq[m].push_back(e);
          pq[m].push_back(p);
          exp_pv[m] = 1'b1;
        end
      end
      exp_pend[m] = fq[m].size();
      exp_ghr[m]  = hist[m];
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    bit ep;
    if (started) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("pred_valid[%0d]", m), int'(pv_w[m]), int'(exp_pv[m]));
        if (pv_w[m]) begin
          if (pq[m].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pred_unexpected[%0d]: got pulse expected none (t=%0t)", m, $time);
          end else begin
            ep = pq[m].pop_front();
            chk($sformatf("pred_taken[%0d]", m), int'(pt_w[m]), int'(ep));
          end
        end
        chk($sformatf("mispredict[%0d]", m), int'(mis_w[m]), int'(exp_mis[m]));
        chk($sformatf("orphan[%0d]", m), int'(orph_w[m]), int'(exp_orph[m]));
        chk($sformatf("pending[%0d]", m), int'(pend_w[m]), exp_pend[m]);
        chk($sformatf("ghr[%0d]", m), int'(ghr_w[m]), exp_ghr[m]);
        chk($sformatf("req_ready[%0d]", m), int'(rdy_w[m]), int'(exp_pend[m] != 4));
      end
    end
  end

  task automatic cyc(input bit rv, input logic [7:0] pc, input bit sv, input bit st);
    req_valid = rv;
    req_pc    = pc;
    res_valid = sv;
    res_taken = st;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_pc    = 8'h00;
    res_valid = 1'b0;
    res_taken = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_pc    = 8'h00;
    res_valid = 1'b0;
    res_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_pending", int'(if0.pending), 0);
    chk("rst_pred_valid", int'(if0.pred_valid), 0);
    chk("rst_ghr", int'(if1.ghr), 0);

    // Train pc 5 down to 0 and back up (bimodal instance)
    cyc(1, 8'h05, 0, 0);
    chk("first_pv", int'(if0.pred_valid), 1);
    chk("first_pt", int'(if0.pred_taken), 1);
    chk("first_pend", int'(if0.pending), 1);
    cyc(0, 8'h00, 1, 0);
    chk("mis1", int'(if0.mispredict), 1);
    cyc(1, 8'h05, 0, 0);
    chk("pred2", int'(if0.pred_taken), 1);
    cyc(0, 8'h00, 1, 0);
    chk("mis2", int'(if0.mispredict), 1);
    cyc(1, 8'h05, 0, 0);
    chk("pred3", int'(if0.pred_taken), 0);
    cyc(0, 8'h00, 1, 0);
    chk("mis3", int'(if0.mispredict), 0);
    cyc(1, 8'h05, 0, 0);
    cyc(0, 8'h00, 1, 0);               // saturates at 0
    cyc(1, 8'h05, 0, 0);
    chk("sat_low", int'(if0.pred_taken), 0);
    cyc(0, 8'h00, 1, 1);               // 0 -> 1
    chk("mis_up", int'(if0.mispredict), 1);
    cyc(1, 8'h05, 0, 0);
    chk("pred_cnt1", int'(if0.pred_taken), 0);
    cyc(0, 8'h00, 1, 1);               // 1 -> 2
    cyc(1, 8'h05, 0, 0);
    chk("pred_cnt2", int'(if0.pred_taken), 1);

    // Fill to DEPTH
    cyc(1, 8'h01, 0, 0);
    cyc(1, 8'h02, 0, 0);
    cyc(1, 8'h03, 0, 0);
    chk("full_pend", int'(if0.pending), 4);
    chk("full_ready", int'(if0.req_ready), 0);
    cyc(1, 8'h07, 0, 0);
    chk("full_nopulse", int'(if0.pred_valid), 0);
    cyc(0, 8'h00, 1, 1);               // pc5: 2 -> 3
    chk("drain_pend", int'(if0.pending), 3);
    chk("drain_ready", int'(if0.req_ready), 1);
    repeat (3) cyc(0, 8'h00, 1, 0);

    // Orphan resolve
    cyc(0, 8'h00, 1, 1);
    chk("orphan", int'(if0.orphan), 1);
    chk("orphan_pend", int'(if0.pending), 0);
    cyc(0, 8'h00, 0, 0);
    chk("orphan_once", int'(if0.orphan), 0);
    cyc(1, 8'h05, 0, 0);
    chk("after_orphan_pt", int'(if0.pred_taken), 1);
    cyc(0, 8'h00, 1, 0);               // 3 -> 2

    // Same-cycle resolve and request on the same index
    cyc(1, 8'h05, 0, 0);
    cyc(1, 8'h05, 1, 0);               // 2 -> 1, prediction uses 2
    chk("same_pv", int'(if0.pred_valid), 1);
    chk("same_pt", int'(if0.pred_taken), 1);
    chk("same_pend", int'(if0.pending), 1);
    cyc(1, 8'h05, 0, 0);
    chk("after_same_pt", int'(if0.pred_taken), 0);
    repeat (2) cyc(0, 8'h00, 1, 1);

    // History instance
    rst_n = 1'b0;
    cyc(0, 8'h00, 0, 0);
    rst_n = 1'b1;
    repeat (4) cyc(1, 8'h00, 0, 0);
    cyc(0, 8'h00, 1, 1);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 1);
    cyc(0, 8'h00, 1, 1);
    chk("ghr_1011", int'(if1.ghr), 11);
    cyc(1, 8'h00, 0, 0);               // idx 11, untouched counter
    chk("hist_pt", int'(if1.pred_taken), 1);
    cyc(1, 8'h20, 0, 0);
    chk("hist_pend2", int'(if1.pending), 2);
    rst_n = 1'b0;
    cyc(0, 8'h00, 0, 0);
    rst_n = 1'b1;
    chk("midrst_pend", int'(if1.pending), 0);
    chk("midrst_ghr", int'(if1.ghr), 0);
    cyc(0, 8'h00, 1, 1);
    chk("midrst_orphan", int'(if1.orphan), 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      cyc($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) != 0);
    end
    rst_n = 1'b1;
    repeat (3) cyc(0, 8'h00, 0, 0);
    chk("pq0_empty", pq[0].size(), 0);
    chk("pq1_empty", pq[1].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised successor of the single 2-bit saturating-counter branch predictor.
- Holds a table of 2^IDX_W saturating counters, each CNT_W bits wide. The table is indexed by the request PC XORed with a committed global history register (gshare). HIST_W=0 gives a plain bimodal predictor.
- Supports up to DEPTH in-flight predictions, resolved strictly in order through an internal FIFO.
- Sits between fetch (issues requests) and execute (reports branch outcomes).

Parameters:
- PC_W, 8, width of req_pc.
- IDX_W, 4, table index width; table has 2^IDX_W entries.
- CNT_W, 2, counter width (legal 1..4); predict taken = counter MSB.
- INIT, 2^CNT_W-1, reset value of every counter (default is strongly taken).
- HIST_W, 0, global history length (legal 0..IDX_W); 0 selects bimodal.
- DEPTH, 4, maximum outstanding unresolved predictions (legal 1..16).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  prediction request.
- req_pc  in  PC_W  branch PC; low IDX_W bits are used.
- req_ready  out  1  request accepted when req_valid && req_ready.
- pred_valid  out  1  one-cycle pulse carrying a prediction.
- pred_taken  out  1  prediction; valid only with pred_valid.
- res_valid  in  1  outcome of the oldest pending prediction.
- res_taken  in  1  actual direction.
- mispredict  out  1  one-cycle pulse when a resolved prediction was wrong.
- orphan  out  1  one-cycle pulse when res_valid arrives with nothing pending.
- pending  out  clog2(DEPTH+1)  number of unresolved predictions.
- ghr  out  max(HIST_W,1)  committed global history; constant 0 when HIST_W=0.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - every counter is set to INIT; ghr=0; FIFO emptied; pending=0.
  - pred_valid, pred_taken, mispredict and orphan all go to 0.
  - Reset mid-operation discards all in-flight entries; no counter update occurs for them.
- req_ready:
  - combinational: req_ready = (pending != DEPTH).
  - It does not depend on a same-cycle res_valid (no full bypass).
- Index computation:
  - idx = req_pc[IDX_W-1:0] XOR zero-extended ghr.
  - ghr is the value held before this edge.
- Request accept (edge N):
  - At N+1: pred_valid=1 and pred_taken = MSB of counter[idx].
  - The counter value used is the one held before edge N.
  - {idx, pred_taken} is pushed into the FIFO.
  - Latency is exactly 1 cycle; back-to-back requests produce back-to-back pulses.
- Resolve (res_valid=1 and pending>0 at edge N):
  - Pop the FIFO head.
  - counter[head.idx] increments if res_taken, otherwise decrements.
  - The counter saturates at 2^CNT_W-1 and at 0; no wrap.
  - ghr <= {ghr[HIST_W-2:0], res_taken}; the newest outcome goes into the LSB.
  - At N+1: mispredict = (head.pred != res_taken) for one cycle.
- Resolve with pending=0:
  - No state change; orphan=1 for one cycle at N+1.
- Simultaneous accept and resolve in the same cycle:
  - Both are performed; pending is unchanged.
  - The prediction reads pre-update counter and ghr values, even when the indexes are equal.
  - The new entry is queued behind all existing entries.
- Requests while full (req_ready=0): ignored, no pulse, no push.
- State: the FIFO is a circular buffer with wrapping read and write pointers plus a count.
- ghr is non-speculative: it changes only on resolve.

Test Plan:
- Reset, then request pc=0x05 (defaults, HIST_W=0) -> next cycle pred_valid=1 and pred_taken=1; pending=1.
- Request pc=5 resolved not-taken three times (counter 3->2->1->0, then saturates at 0):
  - predictions are 1,1,0; mispredict pulses after the first two resolves only.
  - then two taken resolves (0->1->2): next prediction is 1.
- Issue 4 requests with no resolves:
  - pending=4, req_ready=0; a 5th request produces no pred_valid.
  - one resolve -> pending=3 and req_ready=1 on the next cycle.
- res_valid with pending=0 -> orphan pulses once; the counter for the next pc=5 request still predicts as before; ghr unchanged.
- Same cycle: resolve not-taken for idx 5 (counter 2) and a new request pc=5 -> prediction is 1 (old value); a following request predicts 0.
- HIST_W=4:
  - resolve T,N,T,T -> ghr=4'b1011.
  - request pc=0x00 uses idx 11 (counter INIT, prediction 1).
  - assert rst_n=0 with 2 pending -> pending=0 and ghr=0 next cycle; a later resolve raises orphan.
